// File: rtl/ccff_chain_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_pkg
// Shared definitions for the configuration-chain loader:
//   - ccff_state_e : loader FSM states
//   - cnt_width()  : bits needed for a counter that must reach max_val
//   - per-tile chain lengths
// No ports (package).
// ---------------------------------------------------------------------------
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } ccff_state_e;

  // sb_0__1_ switch block: four 2-bit tree-mux memories.
  localparam int SB_0__1_CHAIN_LEN = 8;

  // Width of a counter that counts from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader_if
// Valid/ready stream carrying configuration words into the loader.
//   cfg_data  : configuration word, MSB shifted first
//   cfg_valid : cfg_data is valid
//   cfg_ready : loader accepts the word this cycle
// Modports: master (word source), slave (loader).
// ---------------------------------------------------------------------------
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/ccff_word_serializer.sv
// ---------------------------------------------------------------------------
// ccff_word_serializer
// Holds one configuration word and presents it MSB-first, one bit per
// advance, while counting the bits still left in the word.
// Ports:
//   prog_clk, prog_reset : clock, synchronous active-high reset
//   load, load_data      : capture a new word (word_left = WORD_W)
//   advance              : consume the current MSB
//   msb                  : bit presented to the chain this cycle
//   last_bit             : the current MSB is the final bit of the word
// ---------------------------------------------------------------------------
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              advance,
  output logic              msb,
  output logic              last_bit
);

  localparam int WL_W = cnt_width(WORD_W);

  logic [WORD_W-1:0] sreg_q;
  logic [WORD_W-1:0] sreg_d;
  logic [WL_W-1:0]   word_left_q;
  logic [WL_W-1:0]   word_left_d;

  always_comb begin
    sreg_d      = sreg_q;
    word_left_d = word_left_q;
    if (load) begin
      sreg_d      = load_data;
      word_left_d = WL_W'(WORD_W);
    end else if (advance && (word_left_q != '0)) begin
      sreg_d      = sreg_q << 1;
      word_left_d = word_left_q - 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      sreg_q      <= '0;
      word_left_q <= '0;
    end else begin
      sreg_q      <= sreg_d;
      word_left_q <= word_left_d;
    end
  end

  assign msb      = sreg_q[WORD_W-1];
  assign last_bit = (word_left_q == WL_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
// Programs one routing tile's configuration chain: takes words from a
// valid/ready stream, shifts them MSB-first onto ccff_head with one
// ccff_shift_en pulse per bit, stops after exactly CHAIN_LEN shifts, and
// captures the first RB_W bits leaving ccff_tail as a readback of the old
// configuration. A stream stall longer than TIMEOUT cycles ends the load
// with err_underrun (the chain is left partially shifted, not padded).
// Ports:
//   prog_clk, prog_reset : clock, synchronous active-high reset
//   start                : one-cycle pulse, begins a load (ignored when busy)
//   cfg                  : configuration word stream (slave side)
//   ccff_head            : serial data into the chain (registered)
//   ccff_shift_en        : chain captures ccff_head at the next edge
//   ccff_tail            : serial data out of the chain
//   busy                 : load in progress
//   done, err_underrun   : load finished / ended by timeout; held until start
//   readback             : first RB_W tail bits, first bit at the MSB
// ---------------------------------------------------------------------------
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = SB_0__1_CHAIN_LEN,
  parameter int WORD_W    = 8,
  parameter int RB_W      = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  input  logic                start,
  ccff_chain_loader_if.slave  cfg,
  output logic                ccff_head,
  output logic                ccff_shift_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done,
  output logic                err_underrun,
  output logic [RB_W-1:0]     readback
);

  localparam int BIT_W = cnt_width(CHAIN_LEN);
  localparam int RBC_W = cnt_width(RB_W);
  localparam int TMO_W = cnt_width(TIMEOUT);

  localparam logic [BIT_W-1:0] CHAIN_LEN_C = BIT_W'(CHAIN_LEN);
  localparam logic [RBC_W-1:0] RB_W_C      = RBC_W'(RB_W);
  localparam logic [TMO_W-1:0] TIMEOUT_C   = TMO_W'(TIMEOUT);

  ccff_state_e state_q;
  ccff_state_e state_d;

  logic [BIT_W-1:0] bit_cnt_q;
  logic [BIT_W-1:0] bit_cnt_d;
  logic [RBC_W-1:0] rb_cnt_q;
  logic [RBC_W-1:0] rb_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_d;
  logic [RB_W-1:0]  readback_q;
  logic [RB_W-1:0]  readback_d;
  logic             done_q;
  logic             done_d;
  logic             err_q;
  logic             err_d;
  logic             head_q;
  logic             head_d;
  logic             shift_en_q;
  logic             shift_en_d;

  logic [BIT_W-1:0] bit_inc;
  logic [TMO_W-1:0] tmo_inc;
  logic             chain_full;
  logic             tmo_expire;

  logic ser_load;
  logic ser_advance;
  logic ser_msb;
  logic ser_last;

  ccff_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load       (ser_load),
    .load_data  (cfg.cfg_data),
    .advance    (ser_advance),
    .msb        (ser_msb),
    .last_bit   (ser_last)
  );

  // The shift issued this cycle is the last one of the load.
  assign bit_inc    = bit_cnt_q + 1'b1;
  assign chain_full = (bit_inc == CHAIN_LEN_C);

  // This idle cycle is the TIMEOUT-th consecutive one without a word.
  assign tmo_inc    = tmo_cnt_q + 1'b1;
  assign tmo_expire = (tmo_inc == TIMEOUT_C);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT_WORD;
        end
      end
      ST_WAIT_WORD: begin
        if (cfg.cfg_valid) begin
          state_d = ST_SHIFT;
        end else if (tmo_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        // Chain length wins over word boundary: surplus low bits of the
        // final word are simply dropped.
        if (chain_full) begin
          state_d = ST_DONE;
        end else if (ser_last) begin
          state_d = ST_WAIT_WORD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------
  always_comb begin
    cfg.cfg_ready = 1'b0;
    busy          = 1'b0;
    ser_load      = 1'b0;
    ser_advance   = 1'b0;
    case (state_q)
      ST_WAIT_WORD: begin
        cfg.cfg_ready = 1'b1;
        busy          = 1'b1;
        ser_load      = cfg.cfg_valid;
      end
      ST_SHIFT: begin
        busy        = 1'b1;
        ser_advance = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Counters, readback and registered chain outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rb_cnt_d   = rb_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    readback_d = readback_q;
    done_d     = done_q;
    err_d      = err_q;
    head_d     = head_q;
    shift_en_d = 1'b0;

    // The chain shifts on this edge, so ccff_tail still shows the bit
    // about to fall out: capture it before it is lost.
    if (shift_en_q && (rb_cnt_q < RB_W_C)) begin
      readback_d = RB_W'({readback_q, ccff_tail});
      rb_cnt_d   = rb_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bit_cnt_d  = '0;
          rb_cnt_d   = '0;
          tmo_cnt_d  = '0;
          readback_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      ST_WAIT_WORD: begin
        if (!cfg.cfg_valid) begin
          tmo_cnt_d = tmo_inc;
        end
      end
      ST_SHIFT: begin
        head_d     = ser_msb;
        shift_en_d = 1'b1;
        bit_cnt_d  = bit_inc;
        if (!chain_full && ser_last) begin
          tmo_cnt_d = '0;
        end
      end
      ST_DONE: begin
        // tmo_cnt only reaches TIMEOUT on the underrun path; a normal
        // completion arrives from SHIFT with a smaller count.
        done_d = 1'b1;
        if (tmo_cnt_q == TIMEOUT_C) begin
          err_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      bit_cnt_q  <= '0;
      rb_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
      readback_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rb_cnt_q   <= rb_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      readback_q <= readback_d;
      done_q     <= done_d;
      err_q      <= err_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign done          = done_q;
  assign err_underrun  = err_q;
  assign readback      = readback_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
// Three loader instances with a behavioural chain model each:
//   dut 0 : CHAIN_LEN=8,  TIMEOUT=255
//   dut 1 : CHAIN_LEN=12, TIMEOUT=255
//   dut 2 : CHAIN_LEN=16, TIMEOUT=4
// A table of load records is applied and checked, then hand-written
// sequences cover reset mid-load.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_s [3];
  logic        valid_s [3];
  logic [7:0]  data_s  [3];
  logic        ready_s [3];
  logic        head_s  [3];
  logic        sen_s   [3];
  logic        tail_s  [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        err_s   [3];
  logic [7:0]  rb_s    [3];
  logic        pre_s   [3];
  logic [15:0] pre_val [3];
  logic [15:0] chain_m [3];

  int n_total = 0;
  int n_pass  = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LEN = (gi == 0) ? 8 : ((gi == 1) ? 12 : 16);
    localparam int TMO = (gi == 2) ? 4 : 255;

    ccff_chain_loader_if #(.WORD_W(8)) cif ();

    assign cif.cfg_data  = data_s[gi];
    assign cif.cfg_valid = valid_s[gi];
    assign ready_s[gi]   = cif.cfg_ready;
    assign tail_s[gi]    = chain_m[gi][LEN-1];

    // Chain model: shifts in head on every edge where shift_en is high.
    always @(posedge clk) begin
      if (pre_s[gi]) begin
        chain_m[gi] <= pre_val[gi];
      end else if (sen_s[gi]) begin
        chain_m[gi] <= {chain_m[gi][14:0], head_s[gi]};
      end
    end

    ccff_chain_loader #(
      .CHAIN_LEN (LEN),
      .WORD_W    (8),
      .RB_W      (8),
      .TIMEOUT   (TMO)
    ) u_dut (
      .prog_clk      (clk),
      .prog_reset    (rst),
      .start         (start_s[gi]),
      .cfg           (cif),
      .ccff_head     (head_s[gi]),
      .ccff_shift_en (sen_s[gi]),
      .ccff_tail     (tail_s[gi]),
      .busy          (busy_s[gi]),
      .done          (done_s[gi]),
      .err_underrun  (err_s[gi]),
      .readback      (rb_s[gi])
    );
  end

  typedef struct packed {
    int          d;
    logic [15:0] pre;
    int          nw;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          gap;
    int          restart_k;
    logic [15:0] exp_chain;
    logic [7:0]  exp_rb;
    int          exp_shifts;
    logic [15:0] exp_head;
    logic        exp_err;
    int          exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int len_of(input int d);
    return (d == 0) ? 8 : ((d == 1) ? 12 : 16);
  endfunction

  task automatic check_zero(input int d, input string tag);
    chk({tag, "_head"},     head_s[d],  0);
    chk({tag, "_shift_en"}, sen_s[d],   0);
    chk({tag, "_busy"},     busy_s[d],  0);
    chk({tag, "_ready"},    ready_s[d], 0);
    chk({tag, "_done"},     done_s[d],  0);
    chk({tag, "_err"},      err_s[d],   0);
    chk({tag, "_readback"}, rb_s[d],    0);
  endtask

  task automatic run_row(input int r);
    vec_t        v;
    int          d;
    int          k;
    int          shifts;
    int          done_at;
    int          nacc;
    int          gap_left;
    int          ready_viol;
    logic [15:0] seq;
    logic [15:0] mask;
    logic        acc;
    logic        withheld;
    logic        gap_prev;
    logic        head_last;
    logic        ready_prev;

    v    = vecs[r];
    d    = v.d;
    mask = 16'((32'd1 << len_of(d)) - 1);

    pre_val[d] = v.pre;
    pre_s[d]   = 1'b1;
    tick();
    pre_s[d]   = 1'b0;

    data_s[d]  = v.w0;
    valid_s[d] = 1'b1;
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
    chk("start_clears_done", done_s[d], 0);
    chk("start_sets_busy",   busy_s[d], 1);

    k = 0; shifts = 0; seq = '0; done_at = -1; nacc = 0;
    gap_left = v.gap; gap_prev = 1'b0; ready_viol = 0;
    head_last  = head_s[d];
    ready_prev = ready_s[d];

    while (done_at < 0 && k < 200) begin
      acc        = ready_s[d] && valid_s[d];
      start_s[d] = (k == v.restart_k);
      tick();
      k++;
      start_s[d] = 1'b0;

      if (acc) begin
        nacc++;
        if (nacc < v.nw) begin
          data_s[d]  = v.w1;
          valid_s[d] = (v.gap == 0);
          gap_left   = v.gap;
        end else begin
          valid_s[d] = 1'b0;
        end
      end

      if (sen_s[d]) begin
        shifts++;
        seq = {seq[14:0], head_s[d]};
        if (ready_prev) ready_viol++;
      end

      if (gap_prev) begin
        chk("gap_shift_en",    sen_s[d],  0);
        chk("gap_head_stable", head_s[d], head_last);
      end

      withheld = !valid_s[d] && (nacc < v.nw) && ready_s[d];
      if (withheld) begin
        if (gap_left == 0) valid_s[d] = 1'b1;
        else gap_left--;
      end
      gap_prev   = withheld;
      head_last  = head_s[d];
      ready_prev = ready_s[d];
      if (done_s[d]) done_at = k;
    end
    valid_s[d] = 1'b0;

    chk("done_cycle",         done_at,            v.exp_done);
    chk("shift_count",        shifts,             v.exp_shifts);
    chk("head_sequence",      seq,                v.exp_head);
    chk("chain_contents",     chain_m[d] & mask,  v.exp_chain);
    chk("readback",           rb_s[d],            v.exp_rb);
    chk("err_underrun",       err_s[d],           v.exp_err);
    chk("busy_after_done",    busy_s[d],          0);
    chk("ready_low_in_shift", ready_viol,         0);
    tick();
    chk("done_held",          done_s[d],          1);
    chk("err_held",           err_s[d],           v.exp_err);

    $display("load row %0d dut %0d: shifts=%0d head_seq=0x%0h chain=0x%0h readback=0x%0h done_at=%0d err=%0b",
             r, d, shifts, seq, chain_m[d] & mask, rb_s[d], done_at, err_s[d]);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    int k;

    //         d  pre       nw w0     w1     gap rst  chain     rb     sh  head      err   done
    vecs[0] = '{0, 16'h005A, 1, 8'hC3, 8'h00, 0, -1, 16'h00C3, 8'h5A, 8,  16'h00C3, 1'b0, 10};
    vecs[1] = '{0, 16'h00FF, 1, 8'h00, 8'h00, 0, -1, 16'h0000, 8'hFF, 8,  16'h0000, 1'b0, 10};
    vecs[2] = '{1, 16'h05A5, 2, 8'hAB, 8'hCD, 0, -1, 16'h0ABC, 8'h5A, 12, 16'h0ABC, 1'b0, 15};
    vecs[3] = '{1, 16'h0FFF, 2, 8'hAB, 8'hCD, 5, -1, 16'h0ABC, 8'hFF, 12, 16'h0ABC, 1'b0, 20};
    vecs[4] = '{2, 16'h1234, 1, 8'hFF, 8'h00, 0, -1, 16'h34FF, 8'h12, 8,  16'h00FF, 1'b1, 14};
    vecs[5] = '{2, 16'hC001, 2, 8'h81, 8'h7E, 0, -1, 16'h817E, 8'hC0, 16, 16'h817E, 1'b0, 19};
    vecs[6] = '{0, 16'h003C, 1, 8'hA5, 8'h00, 0,  4, 16'h00A5, 8'h3C, 8,  16'h00A5, 1'b0, 10};

    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      valid_s[i] = 1'b0;
      data_s[i]  = '0;
      pre_s[i]   = 1'b0;
      pre_val[i] = '0;
    end

    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check_zero(i, "reset");
    end
    rst = 1'b0;
    tick();

    for (int r = 0; r < 7; r++) begin
      run_row(r);
    end

    // Reset after three shifts: everything clears on the next edge.
    pre_val[0] = 16'h00FF;
    pre_s[0]   = 1'b1;
    tick();
    pre_s[0]   = 1'b0;
    data_s[0]  = 8'hF0;
    valid_s[0] = 1'b1;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    cnt = 0;
    k   = 0;
    while (cnt < 3 && k < 50) begin
      tick();
      k++;
      if (sen_s[0]) cnt++;
    end
    chk("pre_reset_shifts", cnt, 3);
    chk("pre_reset_busy", busy_s[0], 1);
    rst        = 1'b1;
    valid_s[0] = 1'b0;
    tick();
    check_zero(0, "midload_reset");
    $display("reset mid-load on dut 0 after %0d shifts: busy=%0b readback=0x%0h",
             cnt, busy_s[0], rb_s[0]);
    rst = 1'b0;
    tick();
    run_row(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
